d16_flags: RTL and testbench

- Consumer end of the d16 ALU flag outputs (c, n, o, z).
- Latches flags into an architectural status register on qualifying ALU ops, evaluates branch conditions for the control unit, and saves/restores flags through a small LIFO on interrupt entry and return.
- Sits between the ALU and the d16 control/sequencer.

---
 rtl/d16_flags.sv | 131 +++++++++++++
 tb/tb_d16_flags.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/d16_flags.sv
// d16 status-flag unit: latches ALU flags into the architectural status
// register, evaluates branch conditions one cycle after a request, and
// saves/restores the flags through a small LIFO around interrupts.
module d16_flags #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       alu_c,
    input  logic       alu_n,
    input  logic       alu_o,
    input  logic       alu_z,
    input  logic [2:0] ctrl_alu,
    input  logic       flags_we,
    input  logic       flags_wr,
    input  logic [3:0] flags_wdata,
    input  logic       push,
    input  logic       pop,
    input  logic       cond_valid,
    input  logic [2:0] cond,
    output logic       taken,
    output logic       taken_valid,
    output logic [3:0] flags,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       stack_err,
    input  logic       err_clr
);

    localparam logic [PTR_W:0] SP_FULL = (PTR_W + 1)'(DEPTH);

    logic [3:0]       flags_reg, flags_next;
    logic [PTR_W:0]   sp_reg, sp_next;
    logic             taken_reg, taken_next;
    logic             taken_valid_reg, taken_valid_next;
    logic             stack_err_reg, stack_err_next;
    logic [3:0]       stack_mem [DEPTH];

    logic             push_ok;
    logic             pop_ok;
    logic             err_new;
    logic             alu_qual;
    logic [PTR_W-1:0] pop_idx;

    // Branch condition table over {o,n,z,c}.
    function automatic logic eval_cond(input logic [2:0] code, input logic [3:0] f);
        logic r;
        case (code)
            3'd0:    r = 1'b1;
            3'd1:    r = f[1];
            3'd2:    r = ~f[1];
            3'd3:    r = f[0];
            3'd4:    r = ~f[0];
            3'd5:    r = f[2];
            3'd6:    r = f[3];
            default: r = f[2] ^ f[3];
        endcase
        return r;
    endfunction

    assign stack_empty = (sp_reg == '0);
    assign stack_full  = (sp_reg == SP_FULL);

    // Low pointer bits minus one address the top entry; wraps correctly when full.
    assign pop_idx = sp_reg[PTR_W-1:0] - 1'b1;

    // Stack arbitration, flag priority (pop > write > ALU > hold) and forwarded condition result.
    always_comb begin
        push_ok          = push & ~pop & ~stack_full;
        pop_ok           = pop & ~push & ~stack_empty;
        err_new          = (push & pop) | (push & ~pop & stack_full) | (pop & ~push & stack_empty);
        alu_qual         = flags_we & (ctrl_alu >= 3'd1) & (ctrl_alu <= 3'd4);

        sp_next          = sp_reg;
        flags_next       = flags_reg;
        stack_err_next   = stack_err_reg;
        taken_next       = taken_reg;
        taken_valid_next = cond_valid;

        if (push_ok)
            sp_next = sp_reg + 1'b1;
        else if (pop_ok)
            sp_next = sp_reg - 1'b1;

        if (pop_ok)
            flags_next = stack_mem[pop_idx];
        else if (flags_wr)
            flags_next = flags_wdata;
        else if (alu_qual)
            flags_next = {alu_o, alu_n, alu_z, alu_c};

        // A new error outranks a same-cycle clear.
        if (err_new)
            stack_err_next = 1'b1;
        else if (err_clr)
            stack_err_next = 1'b0;

        if (cond_valid)
            taken_next = eval_cond(cond, flags_next);
    end

    // Architectural state with asynchronous active-low reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            flags_reg       <= 4'b0000;
            sp_reg          <= '0;
            taken_reg       <= 1'b0;
            taken_valid_reg <= 1'b0;
            stack_err_reg   <= 1'b0;
        end else begin
            flags_reg       <= flags_next;
            sp_reg          <= sp_next;
            taken_reg       <= taken_next;
            taken_valid_reg <= taken_valid_next;
            stack_err_reg   <= stack_err_next;
        end
    end

    // Stack storage saves the pre-update flags; contents need no reset.
    always_ff @(posedge sys_clk) begin
        if (push_ok)
            stack_mem[sp_reg[PTR_W-1:0]] <= flags_reg;
    end

    assign flags       = flags_reg;
    assign taken       = taken_reg;
    assign taken_valid = taken_valid_reg;
    assign stack_err   = stack_err_reg;

endmodule

// File: tb/tb_d16_flags.sv
// Directed bench for d16_flags: a queue-based reference model tracks the
// expected state every cycle, plus hand-computed literal checks.
module tb_d16_flags;

    localparam int DEPTH = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       alu_c, alu_n, alu_o, alu_z;
    logic [2:0] ctrl_alu;
    logic       flags_we, flags_wr;
    logic [3:0] flags_wdata;
    logic       push, pop, cond_valid, err_clr;
    logic [2:0] cond;
    logic       taken, taken_valid, stack_empty, stack_full, stack_err;
    logic [3:0] flags;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    d16_flags #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .alu_c(alu_c), .alu_n(alu_n), .alu_o(alu_o), .alu_z(alu_z),
        .ctrl_alu(ctrl_alu), .flags_we(flags_we), .flags_wr(flags_wr),
        .flags_wdata(flags_wdata), .push(push), .pop(pop),
        .cond_valid(cond_valid), .cond(cond),
        .taken(taken), .taken_valid(taken_valid), .flags(flags),
        .stack_empty(stack_empty), .stack_full(stack_full),
        .stack_err(stack_err), .err_clr(err_clr)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model state.
    logic [3:0] m_flags;
    logic [3:0] m_stack[$];
    logic       m_err, m_taken, m_tv;

    function automatic logic ref_cond(input logic [2:0] c, input logic [3:0] f);
        logic o, n, z, cy;
        {o, n, z, cy} = f;
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return cy;
            3'd4: return !cy;
            3'd5: return n;
            3'd6: return o;
            default: return n != o;
        endcase
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        logic [3:0] nf;
        logic       e;
        if (!sys_rst_n) begin
            m_flags = 4'b0000;
            m_stack.delete();
            m_err   = 1'b0;
            m_taken = 1'b0;
            m_tv    = 1'b0;
        end else begin
            nf = m_flags;
            e  = 1'b0;
            if (flags_wr)
                nf = flags_wdata;
            else if (flags_we && ctrl_alu >= 3'd1 && ctrl_alu <= 3'd4)
                nf = {alu_o, alu_n, alu_z, alu_c};
            if (push && pop) begin
                e = 1'b1;
            end else if (push) begin
                if (m_stack.size() == DEPTH) e = 1'b1;
                else m_stack.push_back(m_flags);
            end else if (pop) begin
                if (m_stack.size() == 0) e = 1'b1;
                else nf = m_stack.pop_back();
            end
            if (e) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            m_tv = cond_valid;
            if (cond_valid) m_taken = ref_cond(cond, nf);
            m_flags = nf;
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%b required=%b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle();
        {alu_o, alu_n, alu_z, alu_c} = 4'b0000;
        ctrl_alu = 3'd0; flags_we = 0; flags_wr = 0; flags_wdata = 4'b0000;
        push = 0; pop = 0; cond_valid = 0; cond = 3'd0; err_clr = 0;
    endtask

    // One clock: inputs already driven; clear them after the edge, then compare at the falling edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        idle();
        @(negedge sys_clk);
        cyc++;
        check("model_flags", flags, m_flags);
        check("model_empty", {3'b0, stack_empty}, {3'b0, m_stack.size() == 0});
        check("model_full", {3'b0, stack_full}, {3'b0, m_stack.size() == DEPTH});
        check("model_err", {3'b0, stack_err}, {3'b0, m_err});
        check("model_tv", {3'b0, taken_valid}, {3'b0, m_tv});
        if (m_tv) check("model_taken", {3'b0, taken}, {3'b0, m_taken});
        $display("[TB] cyc %0d flags=%b empty=%b full=%b err=%b tv=%b taken=%b",
                 cyc, flags, stack_empty, stack_full, stack_err, taken_valid, taken);
    endtask

    task automatic wr(input logic [3:0] v);
        flags_wr = 1; flags_wdata = v; tick();
    endtask

    logic [3:0] pushed [4];
    logic [7:0] sweep_exp;

    initial begin
        idle();
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Reset state.
        check("rst_flags", flags, 4'b0000);
        check("rst_empty", {3'b0, stack_empty}, 4'd1);
        check("rst_full", {3'b0, stack_full}, 4'd0);
        check("rst_err", {3'b0, stack_err}, 4'd0);
        check("rst_tv", {3'b0, taken_valid}, 4'd0);
        tick();

        // Qualifying sub with forwarded eq condition: z=0 so eq is not taken.
        flags_we = 1; ctrl_alu = 3'b010; {alu_o, alu_n, alu_z, alu_c} = 4'b0101;
        cond_valid = 1; cond = 3'b001;
        tick();
        check("alu_flags", flags, 4'b0101);
        check("alu_tv", {3'b0, taken_valid}, 4'd1);
        check("alu_taken_eq", {3'b0, taken}, 4'd0);
        // Non-qualifying opcode leaves flags alone; cs forwarded on held flags.
        flags_we = 1; ctrl_alu = 3'b101; {alu_o, alu_n, alu_z, alu_c} = 4'b0000;
        cond_valid = 1; cond = 3'b011;
        tick();
        check("nonq_flags", flags, 4'b0101);
        check("nonq_taken_cs", {3'b0, taken}, 4'd1);
        tick();
        check("tv_drop", {3'b0, taken_valid}, 4'd0);

        // Push saves pre-update flags while an ALU update lands.
        wr(4'b1000);
        push = 1; flags_we = 1; ctrl_alu = 3'b001; {alu_o, alu_n, alu_z, alu_c} = 4'b0010;
        tick();
        check("push_alu_flags", flags, 4'b0010);
        check("push_not_empty", {3'b0, stack_empty}, 4'd0);
        pop = 1; cond_valid = 1; cond = 3'b110;
        tick();
        check("pop_flags", flags, 4'b1000);
        check("pop_empty", {3'b0, stack_empty}, 4'd1);
        check("pop_fwd_vs", {3'b0, taken}, 4'd1);

        // Fill to DEPTH, overflow, clear, then LIFO drain.
        pushed[0] = 4'b0001; pushed[1] = 4'b0010; pushed[2] = 4'b0100; pushed[3] = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            wr(pushed[k]);
            push = 1; tick();
        end
        check("fill_full", {3'b0, stack_full}, 4'd1);
        check("fill_err0", {3'b0, stack_err}, 4'd0);
        push = 1; tick();
        check("ovf_err", {3'b0, stack_err}, 4'd1);
        check("ovf_full", {3'b0, stack_full}, 4'd1);
        err_clr = 1; tick();
        check("clr_err", {3'b0, stack_err}, 4'd0);
        for (int k = 3; k >= 0; k--) begin
            pop = 1; tick();
            check("lifo_pop", flags, pushed[k]);
        end
        check("drain_empty", {3'b0, stack_empty}, 4'd1);

        // Pop on empty falls through to the write.
        pop = 1; flags_wr = 1; flags_wdata = 4'b0110; tick();
        check("upf_flags", flags, 4'b0110);
        check("upf_err", {3'b0, stack_err}, 4'd1);
        // Error beats a same-cycle clear.
        err_clr = 1; push = 1; pop = 1; tick();
        check("err_wins", {3'b0, stack_err}, 4'd1);
        err_clr = 1; tick();
        push = 1; tick();
        push = 1; tick();
        push = 1; pop = 1; flags_wr = 1; flags_wdata = 4'b1111; tick();
        check("pp_flags", flags, 4'b1111);
        check("pp_err", {3'b0, stack_err}, 4'd1);
        check("pp_full", {3'b0, stack_full}, 4'd0);
        pop = 1; tick();
        check("pp_pop1", flags, 4'b0110);
        pop = 1; tick();
        check("pp_pop2", flags, 4'b0110);
        check("pp_empty", {3'b0, stack_empty}, 4'd1);

        // Condition sweep on flags 1000.
        wr(4'b1000);
        sweep_exp = 8'b11010101;
        for (int i = 0; i < 8; i++) begin
            cond_valid = 1; cond = 3'(i); tick();
            check("sweep_taken", {3'b0, taken}, {3'b0, sweep_exp[i]});
        end

        // Reset mid-operation.
        cond_valid = 1; cond = 3'd0;
        @(posedge sys_clk);
        #1;
        idle();
        check("pre_rst_tv", {3'b0, taken_valid}, 4'd1);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_tv", {3'b0, taken_valid}, 4'd0);
        check("mid_rst_flags", flags, 4'b0000);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();
        check("post_rst_tv", {3'b0, taken_valid}, 4'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
